bist_controller: RTL

Sequencer for the multiplier built-in self-test. On a start request it seeds the pattern LFSRs and clears the MISR. It then runs PATTERN_COUNT patterns through the pipelined multiplier and gates MISR compaction to match the multiplier's pipeline latency. Finally it compares the MISR signature against a golden value and reports pass/fail. It sits above the BIST datapath (LFSRs, multiplier, MISR) and drives their enables.

---
 rtl/bist_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bist_controller.sv
// Sequencer for the multiplier BIST: seeds LFSRs, runs PATTERN_COUNT patterns, delays MISR
// compaction by PIPE_LAT, then checks the signature. `BIST_SIG_CAPTURE_EN adds sig_captured.
module bist_controller #(
    parameter int unsigned      PATTERN_COUNT = 255,
    parameter int unsigned      PIPE_LAT      = 3,
    parameter int unsigned      SIG_W         = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             lfsr_seed_load,
    output logic             lfsr_en,
    output logic             misr_clear,
    output logic             misr_en,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [15:0]      pattern_cnt
`ifdef BIST_SIG_CAPTURE_EN
    ,
    output logic [SIG_W-1:0] sig_captured
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_RUN, S_FLUSH, S_COMPARE, S_DONE
    } state_t;

    localparam logic [15:0] LAST_PAT   = 16'(PATTERN_COUNT - 1);
    localparam logic [3:0]  LAST_FLUSH = 4'(PIPE_LAT - 1);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [3:0]          flush_q, flush_d;
    logic [PIPE_LAT-1:0] shreg_q, shreg_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0]    sig_q, sig_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        flush_d        = flush_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        lfsr_seed_load = 1'b0;
        misr_clear     = 1'b0;
        lfsr_en        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
        sig_d          = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEED;
                    cnt_d   = '0;
`ifdef BIST_SIG_CAPTURE_EN
                    sig_d   = '0;
`endif
                end
            end
            S_SEED: begin
                busy           = 1'b1;
                lfsr_seed_load = 1'b1;
                misr_clear     = 1'b1;
                state_d        = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == LAST_PAT) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end
            end
            S_FLUSH: begin
                busy    = 1'b1;
                flush_d = flush_q + 4'd1;
                if (flush_q == LAST_FLUSH) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                busy    = 1'b1;
                state_d = S_DONE;
                pass_d  = (misr_sig == GOLDEN_SIG);
                fail_d  = (misr_sig != GOLDEN_SIG);
`ifdef BIST_SIG_CAPTURE_EN
                sig_d   = misr_sig;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
                    sig_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The pattern issued in the abort cycle still counts, so cnt_d is left alone.
        if (busy && abort) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
`ifdef BIST_SIG_CAPTURE_EN
            sig_d   = misr_sig;
`endif
        end
    end

    // misr_en is lfsr_en delayed by PIPE_LAT; an abort flushes the pipeline immediately.
    always_comb begin
        shreg_d    = '0;
        shreg_d[0] = lfsr_en;
        for (int i = 1; i < int'(PIPE_LAT); i++) shreg_d[i] = shreg_q[i-1];
        if (busy && abort) shreg_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flush_q <= '0;
            shreg_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            shreg_q <= shreg_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
`ifdef BIST_SIG_CAPTURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign misr_en     = shreg_q[PIPE_LAT-1];
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign pattern_cnt = cnt_q;
`ifdef BIST_SIG_CAPTURE_EN
    assign sig_captured = sig_q;
`endif

endmodule
